// File: rtl/tag_port_arbiter.sv
// Write-port controller for a cache tag RAM: arbitrates refill, cache-op and
// flush-sweep writes onto one registered write port and flags read/write hazards.
module tag_port_arbiter #(
    parameter int SET_NUM = 64,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 32
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             refill_req,
    input  logic [IDX_W-1:0] refill_idx,
    input  logic [TAG_W-1:0] refill_tag,
    output logic             refill_ack,
    input  logic             cop_req,
    input  logic [IDX_W-1:0] cop_idx,
    input  logic [TAG_W-1:0] cop_tag,
    output logic             cop_ack,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_stall,
    output logic             ram_ena,
    output logic [3:0]       ram_wea,
    output logic [IDX_W-1:0] ram_addra,
    output logic [TAG_W-1:0] ram_dina,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] LAST_SET = (IDX_W+1)'(SET_NUM - 1);

    // Handshake: a requester holds req (and its idx/tag) stable until it sees
    // ack high; the write is accepted on the clka edge where req && ack, and
    // appears on ram_* during the following cycle.

    state_t           state, state_nx;
    logic [IDX_W:0]   cnt, cnt_nx;
    logic             ena_nx;
    logic [IDX_W-1:0] addr_nx;
    logic [TAG_W-1:0] din_nx;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ena_nx     = 1'b0;
        addr_nx    = '0;
        din_nx     = '0;
        refill_ack = 1'b0;
        cop_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    // First sweep write (set 0) is issued on the entry edge so
                    // ram_* carry sweep writes exactly during FLUSH.
                    state_nx = FLUSH;
                    cnt_nx   = '0;
                    ena_nx   = 1'b1;
                end else if (refill_req) begin
                    refill_ack = 1'b1;
                    ena_nx     = 1'b1;
                    addr_nx    = refill_idx;
                    din_nx     = refill_tag;
                end else if (cop_req) begin
                    cop_ack = 1'b1;
                    ena_nx  = 1'b1;
                    addr_nx = cop_idx;
                    din_nx  = cop_tag;
                end
            end
            FLUSH: begin
                if (cnt == LAST_SET) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx  = cnt + (IDX_W+1)'(1);
                    ena_nx  = 1'b1;
                    addr_nx = cnt_nx[IDX_W-1:0];
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (!rst_n) begin
            refill_ack = 1'b0;
            cop_ack    = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_ena   <= 1'b0;
            ram_wea   <= 4'h0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ram_ena   <= ena_nx;
            ram_wea   <= ena_nx ? 4'hF : 4'h0;
            ram_addra <= addr_nx;
            ram_dina  <= din_nx;
        end
    end

    assign flush_busy = (state == FLUSH);
    assign flush_done = (state == DONE);
    // The read port is registered, so a same-set write in flight returns stale data.
    assign lookup_stall = (ram_ena && (ram_addra == lookup_idx)) || (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_tag_port_arbiter.sv
// Bench for tag_port_arbiter: cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tag_port_arbiter;

    localparam int SET_NUM = 64;
    localparam int IDX_W   = 6;
    localparam int TAG_W   = 32;

    // ---------------- clock / reset ----------------
    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic             rst_n;
    logic             refill_req, cop_req, flush_req;
    logic [IDX_W-1:0] refill_idx, cop_idx, lookup_idx;
    logic [TAG_W-1:0] refill_tag, cop_tag;
    logic             refill_ack, cop_ack, flush_busy, flush_done, lookup_stall;
    logic             ram_ena;
    logic [3:0]       ram_wea;
    logic [IDX_W-1:0] ram_addra;
    logic [TAG_W-1:0] ram_dina;
    logic [1:0]       dbg_state;

    tag_port_arbiter #(.SET_NUM(SET_NUM), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clka(clka), .rst_n(rst_n),
        .refill_req(refill_req), .refill_idx(refill_idx), .refill_tag(refill_tag),
        .refill_ack(refill_ack),
        .cop_req(cop_req), .cop_idx(cop_idx), .cop_tag(cop_tag), .cop_ack(cop_ack),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .lookup_idx(lookup_idx), .lookup_stall(lookup_stall),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit stop    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // sweep_pos: set currently being swept (-1 when no sweep); done_now: the
    // single flush-complete cycle; w_*: the write the RAM port carries now.
    int               sweep_pos = -1;
    bit               done_now  = 1'b0;
    bit               w_valid   = 1'b0;
    logic [IDX_W-1:0] w_addr    = '0;
    logic [TAG_W-1:0] w_data    = '0;

    initial begin : compare
        bit busy, idle, g_ref, g_cop, stall;
        while (!stop) begin
            @(negedge clka);
            busy  = (sweep_pos >= 0);
            idle  = !busy && !done_now;
            g_ref = rst_n && idle && !flush_req && refill_req;
            g_cop = rst_n && idle && !flush_req && !refill_req && cop_req;
            stall = busy || done_now || (w_valid && (w_addr == lookup_idx));
            check("m_refill_ack", 32'(refill_ack), 32'(g_ref));
            check("m_cop_ack", 32'(cop_ack), 32'(g_cop));
            check("m_flush_busy", 32'(flush_busy), 32'(busy));
            check("m_flush_done", 32'(flush_done), 32'(done_now));
            check("m_lookup_stall", 32'(lookup_stall), 32'(stall));
            check("m_ram_ena", 32'(ram_ena), 32'(w_valid));
            check("m_ram_wea", 32'(ram_wea), w_valid ? 32'hF : 32'h0);
            check("m_ram_addra", 32'(ram_addra), 32'(w_addr));
            check("m_ram_dina", ram_dina, w_data);
            // advance to what the next cycle must look like
            w_valid = 1'b0;
            w_addr  = '0;
            w_data  = '0;
            if (!rst_n) begin
                sweep_pos = -1;
                done_now  = 1'b0;
            end else if (busy) begin
                if (sweep_pos == SET_NUM - 1) begin
                    sweep_pos = -1;
                    done_now  = 1'b1;
                end else begin
                    sweep_pos = sweep_pos + 1;
                    w_valid   = 1'b1;
                    w_addr    = IDX_W'(sweep_pos);
                end
            end else if (done_now) begin
                done_now = 1'b0;
            end else if (flush_req) begin
                sweep_pos = 0;
                w_valid   = 1'b1;
            end else if (g_ref) begin
                w_valid = 1'b1;
                w_addr  = refill_idx;
                w_data  = refill_tag;
            end else if (g_cop) begin
                w_valid = 1'b1;
                w_addr  = cop_idx;
                w_data  = cop_tag;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    initial begin : stimulus
        rst_n      = 1'b0;
        flush_req  = 1'b1;
        refill_req = 1'b1;
        cop_req    = 1'b1;
        refill_idx = '0;
        refill_tag = '0;
        cop_idx    = '0;
        cop_tag    = '0;
        lookup_idx = '0;

        // reset held two cycles with every request high
        @(negedge clka);
        check("rst_ram_ena", 32'(ram_ena), 32'd0);
        check("rst_ram_wea", 32'(ram_wea), 32'd0);
        check("rst_ram_addra", 32'(ram_addra), 32'd0);
        check("rst_ram_dina", ram_dina, 32'd0);
        check("rst_refill_ack", 32'(refill_ack), 32'd0);
        check("rst_cop_ack", 32'(cop_ack), 32'd0);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clka);
        check("rel_refill_ack_flush_wins", 32'(refill_ack), 32'd0);
        check("rel_cop_ack_flush_wins", 32'(cop_ack), 32'd0);
        tick();

        // flush pulse with refill held: 64-write sweep, done pulse, then refill
        flush_req = 1'b0;
        cop_req   = 1'b0;
        for (int i = 0; i < SET_NUM; i++) begin
            lookup_idx = IDX_W'(63 - i);
            @(negedge clka);
            check("sweep_addr", 32'(ram_addra), 32'(i));
            check("sweep_dina", ram_dina, 32'd0);
            check("sweep_busy", 32'(flush_busy), 32'd1);
            check("sweep_no_ack", 32'(refill_ack), 32'd0);
            tick();
        end
        @(negedge clka);
        check("done_pulse", 32'(flush_done), 32'd1);
        check("done_ram_ena", 32'(ram_ena), 32'd0);
        check("done_no_ack", 32'(refill_ack), 32'd0);
        tick();
        @(negedge clka);
        check("post_done_refill_ack", 32'(refill_ack), 32'd1);
        check("post_done_pulse_gone", 32'(flush_done), 32'd0);
        tick();
        refill_req = 1'b0;

        // single refill
        refill_req = 1'b1;
        refill_idx = 6'd5;
        refill_tag = 32'h8000_1234;
        @(negedge clka);
        check("single_ack", 32'(refill_ack), 32'd1);
        tick();
        refill_req = 1'b0;
        @(negedge clka);
        check("single_ena", 32'(ram_ena), 32'd1);
        check("single_wea", 32'(ram_wea), 32'hF);
        check("single_addr", 32'(ram_addra), 32'd5);
        check("single_din", ram_dina, 32'h8000_1234);
        tick();

        // refill and cop contend
        refill_req = 1'b1;
        refill_idx = 6'd3;
        refill_tag = 32'h8000_0003;
        cop_req    = 1'b1;
        cop_idx    = 6'd7;
        cop_tag    = 32'h0000_0007;
        @(negedge clka);
        check("cont_refill_ack", 32'(refill_ack), 32'd1);
        check("cont_cop_wait", 32'(cop_ack), 32'd0);
        tick();
        refill_req = 1'b0;
        @(negedge clka);
        check("cont_cop_ack", 32'(cop_ack), 32'd1);
        check("cont_addr_3", 32'(ram_addra), 32'd3);
        tick();
        cop_req = 1'b0;
        @(negedge clka);
        check("cont_addr_7", 32'(ram_addra), 32'd7);
        check("cont_din_7", ram_dina, 32'h0000_0007);
        tick();

        // lookup hazard against a write in flight to set 9
        refill_req = 1'b1;
        refill_idx = 6'd9;
        refill_tag = 32'h8000_0009;
        tick();
        refill_req = 1'b0;
        lookup_idx = 6'd9;
        @(negedge clka);
        check("hazard_same_set", 32'(lookup_stall), 32'd1);
        lookup_idx = 6'd10;
        #1;
        check("hazard_other_set", 32'(lookup_stall), 32'd0);
        tick();

        // invalidate of the top set by the cache-op unit (V=0)
        cop_req = 1'b1;
        cop_idx = 6'd63;
        cop_tag = 32'h0000_0ABC;
        @(negedge clka);
        check("inv_ack", 32'(cop_ack), 32'd1);
        tick();
        cop_req = 1'b0;
        @(negedge clka);
        check("inv_addr", 32'(ram_addra), 32'd63);
        check("inv_din", ram_dina, 32'h0000_0ABC);
        tick();

        // reset in the middle of a sweep
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        @(negedge clka);
        check("midrst_addr20", 32'(ram_addra), 32'd20);
        tick();
        rst_n = 1'b1;
        @(negedge clka);
        check("midrst_ena_off", 32'(ram_ena), 32'd0);
        check("midrst_idle", 32'(dbg_state), 32'd0);
        check("midrst_no_done", 32'(flush_done), 32'd0);
        repeat (4) tick();

        stop = 1'b1;
        repeat (2) @(posedge clka);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tag_port_arbiter.md
Name: tag_port_arbiter

Overview:
- Controller in front of one cache tag RAM (SET_NUM entries, 32-bit tag word, one write port, one registered read port).
- Shares the single write port among three requesters:
  - refill FSM: writes a new tag after a line fill;
  - CACHE-instruction unit: index store-tag / invalidate;
  - flush engine: sweeps every set to zero on a flush command.
- Raises a stall for the lookup stage when a lookup would read a set being written.

Parameters:
- SET_NUM, 64, number of sets; power of two.
- IDX_W, 6, index width; log2(SET_NUM).
- TAG_W, 32, tag word width. Bit TAG_W-1 is the line valid bit V.

Ports:
- clka  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- refill_req  in  1  refill write request; held until accepted.
- refill_idx  in  IDX_W  refill set index.
- refill_tag  in  TAG_W  refill tag word; V=1 expected.
- refill_ack  out  1  accept strobe (combinational).
- cop_req  in  1  cache-op write request; held until accepted.
- cop_idx  in  IDX_W  cache-op set index.
- cop_tag  in  TAG_W  cache-op tag word; V=0 means invalidate.
- cop_ack  out  1  accept strobe (combinational).
- flush_req  in  1  start a full sweep; sampled only in IDLE.
- flush_busy  out  1  high while in FLUSH.
- flush_done  out  1  one-cycle pulse after the last set is written.
- lookup_idx  in  IDX_W  index the lookup stage presents to the read port this cycle.
- lookup_stall  out  1  lookup must retry next cycle.
- ram_ena  out  1  RAM write enable (registered).
- ram_wea  out  4  RAM byte enables (registered); 4'hF on every write.
- ram_addra  out  IDX_W  RAM write index (registered).
- ram_dina  out  TAG_W  RAM write data (registered).

Behaviour:
- Reset values, after a clka edge with rst_n=0:
  - state=IDLE, sweep counter=0;
  - ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0;
  - flush_busy=0, flush_done=0.
  - refill_ack and cop_ack are 0 while rst_n=0.
- States: IDLE, FLUSH, DONE.
- IDLE:
  - Priority order: flush_req > refill_req > cop_req.
  - If flush_req=1: no ack this cycle; next state FLUSH, counter=0.
  - Else if refill_req=1: refill_ack=1. Next cycle drive ram_ena=1, ram_wea=4'hF, ram_addra=refill_idx, ram_dina=refill_tag.
  - Else if cop_req=1: cop_ack=1. Same write timing with cop_idx/cop_tag.
  - Otherwise the ram_* outputs are 0 next cycle.
  - Handshake: a request is accepted on the edge where req&&ack=1; the write reaches the RAM one cycle later.
  - Back-to-back accepts are allowed, one per cycle. A requester may present a new request in the cycle after its ack.
- FLUSH:
  - Each cycle drive ram_ena=1, ram_wea=4'hF, ram_addra=counter, ram_dina=0, then increment counter.
  - After the write with counter=SET_NUM-1, go to DONE. The sweep is exactly SET_NUM consecutive write cycles.
  - refill_ack=cop_ack=0 throughout; pending requests wait.
  - flush_req is ignored during the sweep.
- DONE:
  - flush_done=1 for one cycle, ram_ena=0, no acks.
  - Return to IDLE. A flush_req still high in IDLE starts a new sweep.
- flush_busy=1 exactly during the FLUSH cycles, i.e. the cycles ram_* carry sweep writes.
- lookup_stall (combinational) is 1 when either:
  - ram_ena=1 && ram_addra==lookup_idx (write in flight to the same set; the registered read would return stale data); or
  - state is FLUSH or DONE.
  - Otherwise 0.
- Invalidation semantics: the RAM marks a set present on any write. Software invalidate therefore writes V=0; the downstream hit compare requires V=1.
- Reset mid-sweep: abandon the sweep, counter=0, no flush_done pulse, ram_ena=0 next cycle.
- Simultaneous refill_req and cop_req: refill wins; cop_req stays pending and is acked in the first later IDLE cycle with no flush_req or refill_req.
- Counter width is IDX_W+1 so the terminal compare never wraps.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all reqs high → all ram_* = 0, both acks 0, flush_busy=0; first IDLE cycle after release grants flush.
- Single refill: refill_req=1, idx=5, tag=32'h8000_1234 → refill_ack=1 that cycle; next cycle ram_ena=1, ram_wea=4'hF, ram_addra=5, ram_dina=32'h8000_1234.
- Contention: refill (idx=3) and cop (idx=7) both requested in cycle 0 → refill_ack in cycle 0, cop_ack in cycle 1; RAM writes to 3 then 7 in cycles 1 and 2.
- Flush:
  - pulse flush_req one cycle with refill_req held → 64 consecutive writes, addresses 0..63, data 0;
  - flush_busy high for those 64 cycles, then flush_done high 1 cycle;
  - refill_ack first asserted in the cycle after DONE.
- Hazard: write in flight to idx 9, lookup_idx=9 → lookup_stall=1; same cycle with lookup_idx=10 → lookup_stall=0.
- Reset mid-sweep: assert rst_n=0 at sweep address 20 → ram_ena=0 next cycle, no flush_done pulse, state IDLE.
